// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for the shared RAM data port: port 0 has fixed priority,
// and a wait counter forces a grant to port 1 after MAX_WAIT consecutive losses.
module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_i,
  input  logic [1:0][31:0]      addr_i,
  input  logic [1:0]            we_i,
  input  logic [1:0][3:0]       be_i,
  input  logic [1:0][31:0]      wdata_i,
  output logic [1:0]            gnt_o,
  output logic [1:0]            rvalid_o,
  output logic [31:0]           rdata_o,
  output logic                  err_o,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_port_q, resp_port_d;
  logic        resp_we_q, resp_we_d;
  logic        resp_err_q, resp_err_d;

  logic        win_vld;
  logic        win_port;
  logic        grant;
  logic [31:0] addr_sel;
  logic        in_range;

  always_comb begin
    win_vld  = 1'b0;
    win_port = 1'b0;
    if (req_i[1] && (!req_i[0] || (wait_cnt_q == MAX_WAIT_C))) begin
      win_vld  = 1'b1;
      win_port = 1'b1;
    end else if (req_i[0]) begin
      win_vld  = 1'b1;
      win_port = 1'b0;
    end
  end

  // Reset masks the grant so nothing reaches the RAM or the response path.
  assign grant    = win_vld & ~rst;
  assign addr_sel = addr_i[win_port];
  assign in_range = ((addr_sel >> ADDR_WIDTH) == 32'd0);

  always_comb begin
    gnt_o       = 2'b00;
    ram_en_o    = 1'b0;
    ram_addr_o  = '0;
    ram_we_o    = 1'b0;
    ram_be_o    = 4'b0000;
    ram_wdata_o = 32'd0;
    if (grant) begin
      gnt_o[win_port] = 1'b1;
      ram_en_o        = in_range;
      ram_addr_o      = addr_sel[ADDR_WIDTH-1:0];
      ram_we_o        = we_i[win_port];
      ram_be_o        = be_i[win_port];
      ram_wdata_o     = wdata_i[win_port];
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (grant && win_port) begin
      wait_cnt_d = 4'd0;
    end else if (!req_i[1]) begin
      wait_cnt_d = 4'd0;
    end else if (grant && (wait_cnt_q != MAX_WAIT_C)) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_comb begin
    resp_valid_d = grant;
    resp_port_d  = win_port;
    resp_we_d    = we_i[win_port];
    resp_err_d   = ~in_range;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q   <= 4'd0;
      resp_valid_q <= 1'b0;
      resp_port_q  <= 1'b0;
      resp_we_q    <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_port_q  <= resp_port_d;
      resp_we_q    <= resp_we_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Read data only passes for a valid, in-range read; writes and errors return zero.
  assign rvalid_o[0] = resp_valid_q & ~resp_port_q;
  assign rvalid_o[1] = resp_valid_q & resp_port_q;
  assign err_o       = resp_valid_q & resp_err_q;
  assign rdata_o     = (resp_valid_q && !resp_we_q && !resp_err_q) ? ram_rdata_i : 32'd0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a small word-addressed RAM model on port B.
module tb_ram_port_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_i;
  logic [1:0][31:0] addr_i;
  logic [1:0]       we_i;
  logic [1:0][3:0]  be_i;
  logic [1:0][31:0] wdata_i;
  logic [1:0]       gnt_o;
  logic [1:0]       rvalid_o;
  logic [31:0]      rdata_o;
  logic             err_o;
  logic             ram_en_o;
  logic [7:0]       ram_addr_o;
  logic             ram_we_o;
  logic [3:0]       ram_be_o;
  logic [31:0]      ram_wdata_o;
  logic [31:0]      ram_rdata_i = 32'd0;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [64];

  ram_port_arbiter #(.ADDR_WIDTH(8), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
    .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o), .ram_en_o(ram_en_o),
    .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
  );

  always #5 clk = ~clk;

  // RAM port B model: byte-enabled write at the edge, read data one cycle later.
  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (ram_be_o[b]) mem[ram_addr_o[7:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
      end else begin
        ram_rdata_i <= mem[ram_addr_o[7:2]];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    req_i   = 2'b00;
    we_i    = 2'b00;
    addr_i  = '0;
    be_i    = '0;
    wdata_i = '0;
  endtask

  task automatic set_p(input int p, input logic we, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] d);
    req_i[p]   = 1'b1;
    we_i[p]    = we;
    addr_i[p]  = a;
    be_i[p]    = be;
    wdata_i[p] = d;
  endtask

  task automatic gchk(input string tag, input logic [1:0] g, input logic en);
    chk({tag, "_gnt"}, {30'd0, gnt_o}, {30'd0, g});
    chk({tag, "_en"}, {31'd0, ram_en_o}, {31'd0, en});
  endtask

  task automatic rsp(input string tag, input logic [1:0] rv, input logic er,
                     input logic [31:0] rd);
    chk({tag, "_rvalid"}, {30'd0, rvalid_o}, {30'd0, rv});
    chk({tag, "_err"}, {31'd0, err_o}, {31'd0, er});
    chk({tag, "_rdata"}, rdata_o, rd);
  endtask

  initial begin
    logic [1:0] eg;
    rst = 1'b1;
    idle();
    set_p(0, 1'b1, 32'h10, 4'hF, 32'h55);
    set_p(1, 1'b0, 32'h4, 4'hF, 32'h0);
    #2;
    gchk("rst", 2'b00, 1'b0);
    chk("rst_addr", {24'd0, ram_addr_o}, 32'd0);
    chk("rst_we", {31'd0, ram_we_o}, 32'd0);
    chk("rst_be", {28'd0, ram_be_o}, 32'd0);
    chk("rst_wdata", ram_wdata_o, 32'd0);
    rsp("rst", 2'b00, 1'b0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle();

    // single write then read back
    set_p(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    #1;
    gchk("wr0", 2'b01, 1'b1);
    chk("wr0_addr", {24'd0, ram_addr_o}, 32'h10);
    chk("wr0_we", {31'd0, ram_we_o}, 32'd1);
    chk("wr0_wdata", ram_wdata_o, 32'hDEADBEEF);
    @(negedge clk);
    rsp("wr0", 2'b01, 1'b0, 32'd0);
    idle();
    set_p(0, 1'b0, 32'h10, 4'hF, 32'd0);
    #1;
    gchk("rd0", 2'b01, 1'b1);
    @(negedge clk);
    rsp("rd0", 2'b01, 1'b0, 32'hDEADBEEF);

    // byte-enable merge
    idle();
    set_p(0, 1'b1, 32'h20, 4'hF, 32'd0);
    @(negedge clk);
    rsp("clr", 2'b01, 1'b0, 32'd0);
    idle();
    set_p(0, 1'b1, 32'h20, 4'b0101, 32'h11223344);
    #1;
    chk("be_be", {28'd0, ram_be_o}, 32'h5);
    @(negedge clk);
    rsp("be_wr", 2'b01, 1'b0, 32'd0);
    idle();
    set_p(0, 1'b0, 32'h20, 4'hF, 32'd0);
    @(negedge clk);
    rsp("be_rd", 2'b01, 1'b0, 32'h00220044);

    // alternating owners
    idle();
    set_p(0, 1'b1, 32'h0, 4'hF, 32'hA);
    @(negedge clk);
    rsp("alt_w0", 2'b01, 1'b0, 32'd0);
    idle();
    set_p(1, 1'b1, 32'h4, 4'hF, 32'hB);
    #1;
    gchk("alt_w1", 2'b10, 1'b1);
    @(negedge clk);
    rsp("alt_w1", 2'b10, 1'b0, 32'd0);
    idle();
    set_p(0, 1'b0, 32'h0, 4'hF, 32'd0);
    #1;
    gchk("alt_r0", 2'b01, 1'b1);
    @(negedge clk);
    idle();
    set_p(1, 1'b0, 32'h4, 4'hF, 32'd0);
    rsp("alt_r0", 2'b01, 1'b0, 32'hA);
    #1;
    gchk("alt_r1", 2'b10, 1'b1);
    @(negedge clk);
    rsp("alt_r1", 2'b10, 1'b0, 32'hB);

    // out-of-range read
    idle();
    set_p(1, 1'b0, 32'h100, 4'hF, 32'd0);
    #1;
    gchk("oor", 2'b10, 1'b0);
    @(negedge clk);
    rsp("oor", 2'b10, 1'b1, 32'd0);
    idle();
    @(negedge clk);
    rsp("idle", 2'b00, 1'b0, 32'd0);

    // continuous contention: 0,0,0,0,1 repeating
    for (int k = 0; k < 10; k++) begin
      idle();
      set_p(0, 1'b0, 32'h0, 4'hF, 32'd0);
      set_p(1, 1'b0, 32'h4, 4'hF, 32'd0);
      eg = ((k % 5) == 4) ? 2'b10 : 2'b01;
      #1;
      gchk($sformatf("cont%0d", k), eg, 1'b1);
      @(negedge clk);
      rsp($sformatf("cont%0d", k), eg, 1'b0, (eg == 2'b01) ? 32'hA : 32'hB);
    end
    idle();
    set_p(1, 1'b0, 32'h4, 4'hF, 32'd0);
    #1;
    gchk("p1_alone", 2'b10, 1'b1);
    @(negedge clk);
    rsp("p1_alone", 2'b10, 1'b0, 32'hB);

    // reset while a response is pending
    idle();
    set_p(0, 1'b0, 32'h10, 4'hF, 32'd0);
    @(posedge clk);
    #2;
    rsp("pre_rst", 2'b01, 1'b0, 32'hDEADBEEF);
    rst = 1'b1;
    #1;
    gchk("mid_rst", 2'b00, 1'b0);
    rsp("mid_rst", 2'b00, 1'b0, 32'd0);
    @(negedge clk);
    idle();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rsp("post_rst0", 2'b00, 1'b0, 32'd0);
    @(negedge clk);
    rsp("post_rst1", 2'b00, 1'b0, 32'd0);
    set_p(1, 1'b0, 32'h4, 4'hF, 32'd0);
    #1;
    gchk("post_req", 2'b10, 1'b1);
    @(negedge clk);
    rsp("post_req", 2'b10, 1'b0, 32'hB);
    idle();
    @(negedge clk);
    rsp("final_idle", 2'b00, 1'b0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Shares the single data port (port B) of the testbench dual-port RAM between two requesters: port 0 (core data interface) and port 1 (debug/loader). Each requester uses an OBI-style req/gnt/rvalid handshake. Port 0 has fixed priority, and a wait counter guarantees port 1 forward progress. Out-of-range accesses get an error response and never reach the RAM.

## Interface
Parameters:
- ADDR_WIDTH, 8: RAM byte-address width; must match the RAM instance.
- MAX_WAIT, 4: number of consecutive cycles a requesting port 1 may lose before it is forced to win. Range 0..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_i  in  2  per-port request; bit k belongs to port k.
- addr_i  in  2x32  per-port byte address.
- we_i  in  2  per-port write enable (1 = write).
- be_i  in  2x4  per-port byte enables.
- wdata_i  in  2x32  per-port write data.
- gnt_o  out  2  per-port grant; combinational, at most one bit set.
- rvalid_o  out  2  per-port response valid; registered.
- rdata_o  out  32  response read data, shared by both ports.
- err_o  out  1  response error flag, qualified by rvalid_o.
- ram_en_o  out  1  to RAM en_b_i.
- ram_addr_o  out  ADDR_WIDTH  to RAM addr_b_i.
- ram_we_o  out  1  to RAM we_b_i.
- ram_be_o  out  4  to RAM be_b_i.
- ram_wdata_o  out  32  to RAM wdata_b_i.
- ram_rdata_i  in  32  from RAM rdata_b_o; valid one cycle after an enabled read.

## Operation
- Winner selection, combinational:
  - Port 1 wins if req_i[1] is set and either req_i[0] is clear or wait_cnt == MAX_WAIT.
  - Otherwise port 0 wins if req_i[0] is set.
  - No winner if neither port requests.
- gnt_o is one-hot on the winner and 0 otherwise. gnt_o is forced to 0 while rst is high.
- Range check: an access is in range when addr_i[w][31:ADDR_WIDTH] == 0.
- ram_en_o = grant & in_range. ram_addr_o, ram_we_o, ram_be_o and ram_wdata_o are muxed from the winner; they are all 0 when there is no grant.
- The RAM aligns port-B addresses to words, so addr[1:0] are passed through unchanged and ignored by the RAM.
- wait_cnt, a 4-bit register, reset to 0. Priority order of updates:
  - Set to 0 if port 1 is granted.
  - Set to 0 if req_i[1] is clear.
  - Otherwise incremented when port 0 is granted while req_i[1] is set; saturates at MAX_WAIT.
- With MAX_WAIT = 0, port 1 has strict priority.
- Response registers, all reset to 0: resp_valid_q, resp_port_q, resp_we_q, resp_err_q.
  - Loaded on every edge: resp_valid_q = any grant; resp_port_q = winner; resp_we_q = winner's we_i; resp_err_q = !in_range.
- Response outputs:
  - rvalid_o[k] = resp_valid_q & (resp_port_q == k).
  - err_o = resp_valid_q & resp_err_q.
  - rdata_o = ram_rdata_i for a valid, non-error read; 0 otherwise (writes, errors, idle).
- Every granted access, read or write, produces exactly one rvalid to its owner.
- Requests are not queued. A requester must hold req and its payload until gnt is seen. Dropping req before grant is legal and cancels the request.

## Timing
- Grant and RAM drive happen in the same cycle as req (zero latency).
- Response latency is exactly 1 cycle after the grant cycle, for reads, writes and errors.
- Throughput is 1 access per cycle. Back-to-back grants to different ports produce back-to-back rvalids with the correct owner on each.
- Write data lands in the RAM at the grant edge. A read granted on the next cycle to the same address returns the new data.
- Reset outputs: gnt_o = 0, rvalid_o = 0, err_o = 0, rdata_o = 0, ram_en_o = 0, and all ram_* = 0.
- Reset asserted while a response is pending: the response is discarded and rvalid_o falls to 0 immediately. No response appears after reset is released.
- Both ports request with wait_cnt < MAX_WAIT: port 0 is granted and port 1 sees gnt_o[1] = 0 that cycle.

## Test plan
- Single port 0 write, addr 0x10, be 4'b1111, data 0xDEADBEEF, followed by a read of 0x10. Required: gnt in the same cycle as each req; rvalid_o[0] one cycle after each grant; the read returns rdata 0xDEADBEEF; err 0.
- Byte-enable write: be 4'b0101, data 0x11223344 over 0x00000000. Required: a later read returns 0x00220044.
- Continuous contention, both ports requesting every cycle, MAX_WAIT = 4. Required: grant pattern 0,0,0,0,1 repeating. Port 1 is granted in every 5th cycle and wait_cnt returns to 0 after each port 1 grant.
- Out-of-range access with ADDR_WIDTH = 8: port 1 reads addr 0x100. Required: gnt_o[1] = 1; ram_en_o = 0; the next cycle has rvalid_o[1] = 1, err_o = 1, rdata_o = 0.
- Alternating owners: port 0 reads addr 0x0 (holding 0xA) and is granted, then port 1 reads addr 0x4 (holding 0xB) the next cycle. Required: rvalid_o = 2'b01 with rdata 0xA, followed by rvalid_o = 2'b10 with rdata 0xB.
- Reset mid-operation: assert rst asynchronously in the cycle after a granted read. Required: rvalid_o = 0 and gnt_o = 0 immediately; no response after release; the first request after release is served normally.
